bram_port_arbiter: RTL and testbench

Shares one port of the team's single-clock true dual-port BRAM among NUM_REQ requesters with a valid/ready request handshake. It tracks the RAM's fixed read latency so each read response returns to the requester that issued it. Two instances can serve ports A and B independently. The block sits between client engines (pixel fetch, DMA, debug) and the RAM port pins.

---
 rtl/bram_port_arbiter.sv | 125 ++++++++++++
 tb/tb_bram_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Arbitrates NUM_REQ valid/ready requesters onto one BRAM port and returns read data to the issuer.
// Optional BRAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise fixed priority (lowest index wins).
module bram_port_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 18,
  parameter int READ_LATENCY = 2
) (
  input  logic                       clka,
  input  logic                       rstb,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_din,
  output logic                       mem_we,
  output logic                       mem_en,
  output logic                       mem_regce,
  output logic                       mem_rst,
  input  logic [DATA_W-1:0]          mem_dout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic               grant_any;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;

`ifdef BRAM_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q;
  int unsigned      cand;

  always_ff @(posedge clka) begin
    if (rstb)
      ptr_q <= IDX_W'(NUM_REQ - 1);
    else if (grant_any)
      ptr_q <= grant_idx;
  end

  // Search starts one past the last winner so every requester waits at most NUM_REQ-1 grants.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(ptr_q) + k) % NUM_REQ;
      if (!grant_any && !rstb && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && !rstb && req_valid[k]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (grant_any)
      grant[grant_idx] = 1'b1;
  end

  assign req_ready = grant;

  always_comb begin
    mem_en   = grant_any;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (grant_any) begin
      mem_we   = req_we[grant_idx];
      mem_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
      mem_din  = req_wdata[grant_idx*DATA_W +: DATA_W];
    end
  end

  assign mem_regce = 1'b1;
  assign mem_rst   = rstb;

  // Read tags ride alongside the RAM latency; the response register forms the final stage.
  logic [READ_LATENCY-1:0] tag_v;
  logic [IDX_W-1:0]        tag_idx [READ_LATENCY];
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [DATA_W-1:0]       rsp_data_q;

  always_ff @(posedge clka) begin
    if (rstb) begin
      tag_v       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++)
        tag_idx[i] <= '0;
    end else begin
      tag_v[0]   <= grant_any & ~req_we[grant_idx];
      tag_idx[0] <= grant_idx;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
      rsp_valid_q <= '0;
      if (tag_v[READ_LATENCY-1]) begin
        rsp_valid_q[tag_idx[READ_LATENCY-1]] <= 1'b1;
        rsp_data_q                           <= mem_dout;
      end
    end
  end

  // Gated so outputs read zero from the very first reset cycle, before the registers clear.
  assign rsp_valid = rstb ? '0 : rsp_valid_q;
  assign rsp_data  = rstb ? '0 : rsp_data_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench: two arbiters (READ_LATENCY 2 on port A, 1 on port B) share one true dual-port RAM model.
// Arbitration expectations follow BRAM_ARB_ROUND_ROBIN_EN when defined, fixed priority otherwise.
module tb_bram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 18;

  logic          clka = 1'b0;
  logic          rstb;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;

  logic [N-1:0]  rdy_a, rv_a, rdy_b, rv_b;
  logic [DW-1:0] rd_a, rd_b, mdin_a, mdin_b, mdout_a, mdout_b;
  logic [AW-1:0] maddr_a, maddr_b;
  logic          mwe_a, men_a, mregce_a, mrst_a;
  logic          mwe_b, men_b, mregce_b, mrst_b;

  bram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2)) dut_a (
    .clka(clka), .rstb(rstb), .req_valid(req_valid), .req_ready(rdy_a), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv_a), .rsp_data(rd_a),
    .mem_addr(maddr_a), .mem_din(mdin_a), .mem_we(mwe_a), .mem_en(men_a),
    .mem_regce(mregce_a), .mem_rst(mrst_a), .mem_dout(mdout_a));

  bram_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1)) dut_b (
    .clka(clka), .rstb(rstb), .req_valid(req_valid), .req_ready(rdy_b), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv_b), .rsp_data(rd_b),
    .mem_addr(maddr_b), .mem_din(mdin_b), .mem_we(mwe_b), .mem_en(men_b),
    .mem_regce(mregce_b), .mem_rst(mrst_b), .mem_dout(mdout_b));

  always #5 clka = ~clka;

  // Read-first true dual-port RAM; port A has an output register, port B does not.
  logic [DW-1:0] ram [1024];
  logic [DW-1:0] a_s1;
  always @(posedge clka) begin
    if (men_a) begin
      a_s1 <= ram[maddr_a];
      if (mwe_a) ram[maddr_a] <= mdin_a;
    end
    if (mrst_a) mdout_a <= '0;
    else if (mregce_a) mdout_a <= a_s1;
    if (men_b) begin
      mdout_b <= ram[maddr_b];
      if (mwe_b) ram[maddr_b] <= mdin_b;
    end
  end

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    else
      passes++;
  endtask

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic [DW-1:0] shadow [1024];

`ifdef BRAM_ARB_ROUND_ROBIN_EN
  int ptr_m = N - 1;
  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
`else
  function automatic int model_grant(input logic [N-1:0] v);
    for (int k = 0; k < N; k++)
      if (v[k]) return k;
    return -1;
  endfunction
`endif

  // Reference model: predicts the grant, checks the port drive, and queues expected responses.
  always @(negedge clka) begin
    int            gi;
    logic [AW-1:0] a;
    if (rstb) begin
      chk("rst_ready_a", rdy_a, 0);
      chk("rst_ready_b", rdy_b, 0);
      chk("rst_rsp_valid_a", rv_a, 0);
      chk("rst_rsp_valid_b", rv_b, 0);
      chk("rst_rsp_data_a", rd_a, 0);
      chk("rst_mem_en_a", men_a, 0);
      chk("rst_mem_we_a", mwe_a, 0);
      chk("rst_mem_addr_a", maddr_a, 0);
      chk("rst_mem_din_a", mdin_a, 0);
      chk("rst_mem_rst_a", mrst_a, 1);
      chk("rst_mem_regce_a", mregce_a, 1);
`ifdef BRAM_ARB_ROUND_ROBIN_EN
      ptr_m = N - 1;
`endif
    end else begin
`ifdef BRAM_ARB_ROUND_ROBIN_EN
      gi = model_grant(req_valid, ptr_m);
`else
      gi = model_grant(req_valid);
`endif
      chk("ready_a", rdy_a, (gi >= 0) ? (64'd1 << gi) : 64'd0);
      chk("ready_b", rdy_b, (gi >= 0) ? (64'd1 << gi) : 64'd0);
      chk("mem_en_a", men_a, (gi >= 0) ? 1 : 0);
      if (gi >= 0) begin
        a = req_addr[gi*AW +: AW];
        chk("mem_addr_a", maddr_a, a);
        chk("mem_we_a", mwe_a, req_we[gi]);
        chk("mem_addr_b", maddr_b, a);
        if (req_we[gi]) begin
          chk("mem_din_a", mdin_a, req_wdata[gi*DW +: DW]);
          shadow[a] = req_wdata[gi*DW +: DW];
        end else begin
          qa.push_back('{gi, shadow[a], cyc + 3});
          qb.push_back('{gi, shadow[a], cyc + 2});
        end
`ifdef BRAM_ARB_ROUND_ROBIN_EN
        ptr_m = gi;
`endif
      end
    end
  end

  always @(negedge clka) begin
    if (!rstb) begin
      if (qa.size() > 0 && qa[0].due == cyc) begin
        ea = qa.pop_front();
        chk("rsp_valid_a", rv_a, 64'd1 << ea.idx);
        chk("rsp_data_a", rd_a, ea.data);
      end else if (rv_a != 0) begin
        chk("rsp_spurious_a", rv_a, 0);
      end
    end
  end

  always @(negedge clka) begin
    if (!rstb) begin
      if (qb.size() > 0 && qb[0].due == cyc) begin
        eb = qb.pop_front();
        chk("rsp_valid_b", rv_b, 64'd1 << eb.idx);
        chk("rsp_data_b", rd_b, eb.data);
      end else if (rv_b != 0) begin
        chk("rsp_spurious_b", rv_b, 0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clka);
    #1;
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = 1'b1;
    req_we[i]            = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  typedef struct {
    int            idx;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } vec_t;

  vec_t preload [6] = '{
    '{0, 1'b1, 10'h005, 18'h2A5A3}, '{0, 1'b1, 10'h010, 18'h11111},
    '{0, 1'b1, 10'h011, 18'h22222}, '{0, 1'b1, 10'h012, 18'h33333},
    '{0, 1'b1, 10'h013, 18'h04444}, '{0, 1'b1, 10'h020, 18'h00ABC}};

  vec_t mix [6] = '{
    '{1, 1'b1, 10'h020, 18'h15555}, '{3, 1'b0, 10'h020, 18'h0},
    '{2, 1'b0, 10'h005, 18'h0},     '{0, 1'b1, 10'h020, 18'h2AAAA},
    '{1, 1'b0, 10'h020, 18'h0},     '{3, 1'b0, 10'h3FF, 18'h0}};

  initial begin
    rstb = 1'b1;
    clear_req();
    step(3);
    rstb = 1'b0;

    foreach (preload[j]) begin
      clear_req();
      set_req(preload[j].idx, preload[j].we, preload[j].addr, preload[j].data);
      step(1);
    end
    clear_req();
    step(2);

    set_req(1, 1'b0, 10'h005, '0);
    step(1);
    clear_req();
    step(5);

    set_req(0, 1'b1, 10'h3FF, 18'h3FFFF);
    step(1);
    clear_req();
    set_req(2, 1'b0, 10'h3FF, '0);
    step(1);
    clear_req();
    step(5);

    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(10'h010 + i), '0);
    step(8);
    clear_req();
    step(5);

    set_req(0, 1'b0, 10'h011, '0);
    set_req(3, 1'b0, 10'h013, '0);
    step(3);
    req_valid[0] = 1'b0;
    step(2);
    clear_req();
    step(5);

    foreach (mix[j]) begin
      clear_req();
      set_req(mix[j].idx, mix[j].we, mix[j].addr, mix[j].data);
      step(1);
    end
    clear_req();
    step(5);

    set_req(2, 1'b0, 10'h010, '0);
    step(1);
    clear_req();
    set_req(1, 1'b0, 10'h012, '0);
    step(1);
    clear_req();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(10'h010 + i), '0);
    rstb = 1'b1;
    qa.delete();
    qb.delete();
    step(4);
    rstb = 1'b0;
    step(2);
    clear_req();
    step(8);

    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
